// File: rtl/crossbar_eject_if.sv
// Signal bundle between the crossbar ejection stage and its environment.
// Handshake: a flit leaves the ejection FIFO on a rising edge where eject_valid and eject_ready are both 1; eject_valid never depends on eject_ready.
interface crossbar_eject_if #(
    parameter int CTRL_W = 32,
    parameter int DATA_W = 128
);
    logic [14:0]       route_config;
    logic [CTRL_W-1:0] control0_in, control1_in, control2_in, control3_in, control4_in;
    logic [DATA_W-1:0] data0_in, data1_in, data2_in, data3_in, data4_in;
    logic [CTRL_W-1:0] control0_out, control1_out, control2_out, control3_out;
    logic [DATA_W-1:0] data0_out, data1_out, data2_out, data3_out;
    logic [CTRL_W-1:0] eject_control;
    logic [DATA_W-1:0] eject_data;
    logic              eject_valid;
    logic              eject_ready;
    logic              eject_overflow;
    logic              xbar_err;
    logic [15:0]       flit_count;

    modport slave (
        input  route_config,
        input  control0_in, control1_in, control2_in, control3_in, control4_in,
        input  data0_in, data1_in, data2_in, data3_in, data4_in,
        output control0_out, control1_out, control2_out, control3_out,
        output data0_out, data1_out, data2_out, data3_out,
        output eject_control, eject_data, eject_valid,
        input  eject_ready,
        output eject_overflow, xbar_err, flit_count
    );

    modport master (
        output route_config,
        output control0_in, control1_in, control2_in, control3_in, control4_in,
        output data0_in, data1_in, data2_in, data3_in, data4_in,
        input  control0_out, control1_out, control2_out, control3_out,
        input  data0_out, data1_out, data2_out, data3_out,
        input  eject_control, eject_data, eject_valid,
        output eject_ready,
        input  eject_overflow, xbar_err, flit_count
    );
endinterface

// File: rtl/crossbar_eject.sv
// 5x5 router crossbar: four registered output links plus a resource port that
// feeds a small ejection FIFO toward the local core.
module crossbar_eject #(
    parameter int CTRL_W    = 32,
    parameter int DATA_W    = 128,
    parameter int VALID_BIT = 0,
    parameter int EJ_DEPTH  = 4
) (
    input logic              clk,
    input logic              rst,
    crossbar_eject_if.slave  bus
);
    localparam int PW = $clog2(EJ_DEPTH);
    localparam int EW = CTRL_W + DATA_W;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(EJ_DEPTH);

    logic [CTRL_W-1:0] w_ctrl_in [5];
    logic [DATA_W-1:0] w_data_in [5];
    logic [2:0]        w_sel     [5];

    assign w_ctrl_in[0] = bus.control0_in;
    assign w_ctrl_in[1] = bus.control1_in;
    assign w_ctrl_in[2] = bus.control2_in;
    assign w_ctrl_in[3] = bus.control3_in;
    assign w_ctrl_in[4] = bus.control4_in;
    assign w_data_in[0] = bus.data0_in;
    assign w_data_in[1] = bus.data1_in;
    assign w_data_in[2] = bus.data2_in;
    assign w_data_in[3] = bus.data3_in;
    assign w_data_in[4] = bus.data4_in;

    for (genvar g = 0; g < 5; g++) begin : g_sel
        assign w_sel[g] = bus.route_config[3*g +: 3];
    end

    logic [CTRL_W-1:0] w_link_ctrl [4];
    logic [DATA_W-1:0] w_link_data [4];
    logic [2:0]        w_inc;
    logic              w_push_req;
    logic [EW-1:0]     w_push_flit;
    logic              w_err;

    always_comb begin
        w_inc       = '0;
        w_push_req  = 1'b0;
        w_push_flit = '0;
        for (int k = 0; k < 4; k++) begin
            w_link_ctrl[k] = '0;
            w_link_data[k] = '0;
            if (w_sel[k] <= 3'd4 && w_ctrl_in[w_sel[k]][VALID_BIT]) begin
                w_link_ctrl[k] = w_ctrl_in[w_sel[k]];
                w_link_data[k] = w_data_in[w_sel[k]];
                w_inc          = w_inc + 3'd1;
            end
        end
        if (w_sel[4] <= 3'd4 && w_ctrl_in[w_sel[4]][VALID_BIT]) begin
            w_push_req  = 1'b1;
            w_push_flit = {w_ctrl_in[w_sel[4]], w_data_in[w_sel[4]]};
        end
    end

    // A source driving two outputs, or a reserved code 5/6, flags a bad config.
    always_comb begin
        w_err = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (w_sel[i] == 3'd5 || w_sel[i] == 3'd6) w_err = 1'b1;
            for (int j = i + 1; j < 5; j++) begin
                if (w_sel[i] <= 3'd4 && w_sel[i] == w_sel[j]) w_err = 1'b1;
            end
        end
    end

    logic [EW-1:0]     r_mem [EJ_DEPTH];
    logic [PW-1:0]     r_rd_ptr, r_wr_ptr;
    logic [PW:0]       r_count;
    logic [CTRL_W-1:0] r_link_ctrl [4];
    logic [DATA_W-1:0] r_link_data [4];
    logic              r_overflow, r_err;
    logic [15:0]       r_flit_count;

    logic w_pop, w_full, w_push, w_drop;
    assign w_pop  = (r_count != '0) && bus.eject_ready;
    assign w_full = (r_count == FULL_CNT);
    // When full, a same-cycle pop frees the slot the push lands in.
    assign w_push = w_push_req && (!w_full || w_pop);
    assign w_drop = w_push_req && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                r_link_ctrl[k] <= '0;
                r_link_data[k] <= '0;
            end
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_err        <= 1'b0;
            r_flit_count <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                r_link_ctrl[k] <= w_link_ctrl[k];
                r_link_data[k] <= w_link_data[k];
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
            r_overflow   <= r_overflow | w_drop;
            r_err        <= r_err | w_err;
            r_flit_count <= r_flit_count + 16'(w_inc) + 16'(w_push);
        end
    end

    always_ff @(posedge clk) begin
        if (rst && w_push) r_mem[r_wr_ptr] <= w_push_flit;
    end

    logic [EW-1:0] w_head;
    assign w_head = (r_count != '0) ? r_mem[r_rd_ptr] : '0;

    assign bus.control0_out   = r_link_ctrl[0];
    assign bus.control1_out   = r_link_ctrl[1];
    assign bus.control2_out   = r_link_ctrl[2];
    assign bus.control3_out   = r_link_ctrl[3];
    assign bus.data0_out      = r_link_data[0];
    assign bus.data1_out      = r_link_data[1];
    assign bus.data2_out      = r_link_data[2];
    assign bus.data3_out      = r_link_data[3];
    assign bus.eject_control  = w_head[EW-1:DATA_W];
    assign bus.eject_data     = w_head[DATA_W-1:0];
    assign bus.eject_valid    = (r_count != '0);
    assign bus.eject_overflow = r_overflow;
    assign bus.xbar_err       = r_err;
    assign bus.flit_count     = r_flit_count;
endmodule
